// File: rtl/wqe_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : wqe_sched_pkg
//  Purpose  : Shared definitions for the WQE group scheduler: default widths,
//             FSM state encoding and WQE class codes.
//  Macro    : none (the stats option WQE_SCHED_STATS_EN lives in the top)
//  Revision : 1.0 - initial release
// ============================================================================
package wqe_sched_pkg;

    localparam int DEF_WQE_WIDTH     = 512;
    localparam int DEF_PWQE_SLOT_NUM = 4;
    localparam int DEF_SLOT_IDX_W    = 2;
    localparam int DEF_BURST_W       = 4;

    // Scheduler FSM: grant (IDLE) -> capture read data (FETCH) -> present (OUT)
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        OUT   = 2'd2
    } sched_state_t;

    localparam logic CLS_LS = 1'b0;
    localparam logic CLS_BS = 1'b1;

endpackage : wqe_sched_pkg
`default_nettype wire

// File: rtl/wqe_rr_arb.sv
`default_nettype none
// ============================================================================
//  Module   : wqe_rr_arb
//  Purpose  : Round-robin arbiter over N request lines. The search starts at
//             the internal pointer; after a taken grant the pointer moves to
//             the slot following the winner.
//  Ports    : clk, rst        - clock, synchronous active-high reset
//             i_req [N]       - request vector
//             i_gnt_en        - grant is actually taken this cycle
//             o_gnt [N]       - one-hot grant (zero unless i_gnt_en)
//             o_gnt_idx       - index of the winning request
//             o_any_req       - at least one request is set
//  Revision : 1.0 - initial release
// ============================================================================
module wqe_rr_arb #(
    parameter int N     = 4,
    parameter int IDX_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     i_req,
    input  logic             i_gnt_en,
    output logic [N-1:0]     o_gnt,
    output logic [IDX_W-1:0] o_gnt_idx,
    output logic             o_any_req
);

    logic [IDX_W-1:0] r_rr_ptr;
    logic [IDX_W-1:0] w_idx;
    logic             w_found;
    int               w_pos;

    // First requester at or after r_rr_ptr, wrapping modulo N
    always_comb begin
        w_idx   = r_rr_ptr;
        w_found = 1'b0;
        w_pos   = 0;
        for (int i = 0; i < N; i++) begin
            w_pos = int'(r_rr_ptr) + i;
            if (w_pos >= N) w_pos = w_pos - N;
            if (!w_found && i_req[IDX_W'(w_pos)]) begin
                w_found = 1'b1;
                w_idx   = IDX_W'(w_pos);
            end
        end
    end

    assign o_any_req = w_found;
    assign o_gnt_idx = w_idx;
    assign o_gnt     = (i_gnt_en && w_found) ? ({{(N-1){1'b0}}, 1'b1} << w_idx) : '0;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rr_ptr <= '0;
        end else if (i_gnt_en && w_found) begin
            r_rr_ptr <= (w_idx == IDX_W'(N-1)) ? '0 : w_idx + 1'b1;
        end
    end

endmodule : wqe_rr_arb
`default_nettype wire

// File: rtl/wqe_grp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : wqe_grp_scheduler
//  Purpose  : Shares the single WQE issue path between the latency-sensitive
//             (LS) queue and the bandwidth-sensitive (BS) slot FIFOs. LS wins
//             unless it has used i_ls_burst_max consecutive grants while BS
//             was waiting; BS slots are served round-robin. One read in
//             flight: grant (IDLE) -> capture (FETCH) -> hold until accepted.
//  Ports    : clk, rst           - clock, synchronous active-high reset
//             i_sched_en         - allow new grants
//             i_ls_burst_max     - LS burst limit (0 = strict LS priority)
//             i_ls_empty/o_ls_ren/i_ls_rdata            - LS queue
//             i_bs_fifo_empty/o_bs_fifo_rd/i_bs_wqe_val/i_bs_wqe - BS slots
//             o_wqe_val/o_wqe/o_wqe_cls/o_wqe_slot/i_wqe_rdy     - output
//  Macro    : WQE_SCHED_STATS_EN adds o_ls_grant_cnt, o_bs_grant_cnt and
//             o_starve_cnt (32-bit wrapping grant counters).
//  Revision : 1.0 - initial release
// ============================================================================
module wqe_grp_scheduler
    import wqe_sched_pkg::*;
#(
    parameter int WQE_WIDTH     = DEF_WQE_WIDTH,
    parameter int PWQE_SLOT_NUM = DEF_PWQE_SLOT_NUM,
    parameter int SLOT_IDX_W    = DEF_SLOT_IDX_W,
    parameter int BURST_W       = DEF_BURST_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     i_sched_en,
    input  logic [BURST_W-1:0]       i_ls_burst_max,
    input  logic                     i_ls_empty,
    output logic                     o_ls_ren,
    input  logic [WQE_WIDTH-1:0]     i_ls_rdata,
    input  logic [PWQE_SLOT_NUM-1:0] i_bs_fifo_empty,
    output logic [PWQE_SLOT_NUM-1:0] o_bs_fifo_rd,
    input  logic                     i_bs_wqe_val,
    input  logic [WQE_WIDTH-1:0]     i_bs_wqe,
    output logic                     o_wqe_val,
    output logic [WQE_WIDTH-1:0]     o_wqe,
    output logic                     o_wqe_cls,
    input  logic                     i_wqe_rdy,
`ifdef WQE_SCHED_STATS_EN
    output logic [31:0]              o_ls_grant_cnt,
    output logic [31:0]              o_bs_grant_cnt,
    output logic [31:0]              o_starve_cnt,
`endif
    output logic [SLOT_IDX_W-1:0]    o_wqe_slot
);

    sched_state_t            r_state;
    logic                    r_cls;
    logic [SLOT_IDX_W-1:0]   r_slot;
    logic [BURST_W-1:0]      r_burst_cnt;

    logic                    w_ls_req;
    logic                    w_bs_req;
    logic                    w_force_bs;
    logic                    w_grant_ok;
    logic                    w_ls_take;
    logic                    w_bs_take;
    logic [SLOT_IDX_W-1:0]   w_bs_idx;

    assign w_ls_req   = ~i_ls_empty;
    assign w_force_bs = w_bs_req && (i_ls_burst_max != '0) && (r_burst_cnt >= i_ls_burst_max);
    assign w_grant_ok = !rst && i_sched_en && (r_state == IDLE);
    assign w_ls_take  = w_grant_ok && w_ls_req && !w_force_bs;
    assign w_bs_take  = w_grant_ok && w_bs_req && !w_ls_take;

    wqe_rr_arb #(
        .N     (PWQE_SLOT_NUM),
        .IDX_W (SLOT_IDX_W)
    ) u_bs_arb (
        .clk       (clk),
        .rst       (rst),
        .i_req     (~i_bs_fifo_empty),
        .i_gnt_en  (w_bs_take),
        .o_gnt     (o_bs_fifo_rd),
        .o_gnt_idx (w_bs_idx),
        .o_any_req (w_bs_req)
    );

    // Read pulses are issued in the grant cycle itself so that the read data
    // lands in FETCH; this is what gives the 3-cycle issue period.
    assign o_ls_ren   = w_ls_take;
    assign o_wqe_cls  = r_cls;
    assign o_wqe_slot = r_slot;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_cls       <= CLS_LS;
            r_slot      <= '0;
            r_burst_cnt <= '0;
            o_wqe_val   <= 1'b0;
            o_wqe       <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_ls_take) begin
                        r_cls   <= CLS_LS;
                        r_slot  <= '0;
                        r_state <= FETCH;
                        // Only LS grants made while BS waits count toward the burst
                        if (!w_bs_req)
                            r_burst_cnt <= '0;
                        else if (!(&r_burst_cnt))
                            r_burst_cnt <= r_burst_cnt + 1'b1;
                    end else if (w_bs_take) begin
                        r_cls       <= CLS_BS;
                        r_slot      <= w_bs_idx;
                        r_burst_cnt <= '0;
                        r_state     <= FETCH;
                    end
                end
                FETCH: begin
                    // A missing BS valid is a source protocol error; the
                    // entry is still presented so the pipeline cannot stall.
                    assert (r_cls != CLS_BS || i_bs_wqe_val);
                    o_wqe     <= (r_cls == CLS_BS) ? i_bs_wqe : i_ls_rdata;
                    o_wqe_val <= 1'b1;
                    r_state   <= OUT;
                end
                OUT: begin
                    if (i_wqe_rdy) begin
                        o_wqe_val <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

`ifdef WQE_SCHED_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            o_ls_grant_cnt <= '0;
            o_bs_grant_cnt <= '0;
            o_starve_cnt   <= '0;
        end else begin
            if (w_ls_take) o_ls_grant_cnt <= o_ls_grant_cnt + 32'd1;
            if (w_bs_take) o_bs_grant_cnt <= o_bs_grant_cnt + 32'd1;
            // A BS grant with LS pending can only come from the burst guard
            if (w_bs_take && w_ls_req) o_starve_cnt <= o_starve_cnt + 32'd1;
        end
    end
`endif

endmodule : wqe_grp_scheduler
`default_nettype wire

// File: tb/tb_wqe_grp_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wqe_grp_scheduler
//  Purpose  : Self-checking bench for wqe_grp_scheduler. The bench owns the
//             LS queue and BS slot FIFOs as queues of WQEs and predicts every
//             cycle's read pulses and output WQE from the arbitration rules.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_wqe_grp_scheduler;

    localparam int W  = 512;
    localparam int NS = 4;
    localparam int IW = 2;
    localparam int BW = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_sched_en;
    logic [BW-1:0] i_ls_burst_max;
    logic          i_ls_empty;
    logic          o_ls_ren;
    logic [W-1:0]  i_ls_rdata;
    logic [NS-1:0] i_bs_fifo_empty;
    logic [NS-1:0] o_bs_fifo_rd;
    logic          i_bs_wqe_val;
    logic [W-1:0]  i_bs_wqe;
    logic          o_wqe_val;
    logic [W-1:0]  o_wqe;
    logic          o_wqe_cls;
    logic [IW-1:0] o_wqe_slot;
    logic          i_wqe_rdy;
`ifdef WQE_SCHED_STATS_EN
    logic [31:0]   o_ls_grant_cnt, o_bs_grant_cnt, o_starve_cnt;
`endif

    wqe_grp_scheduler dut (
        .clk             (clk),
        .rst             (rst),
        .i_sched_en      (i_sched_en),
        .i_ls_burst_max  (i_ls_burst_max),
        .i_ls_empty      (i_ls_empty),
        .o_ls_ren        (o_ls_ren),
        .i_ls_rdata      (i_ls_rdata),
        .i_bs_fifo_empty (i_bs_fifo_empty),
        .o_bs_fifo_rd    (o_bs_fifo_rd),
        .i_bs_wqe_val    (i_bs_wqe_val),
        .i_bs_wqe        (i_bs_wqe),
        .o_wqe_val       (o_wqe_val),
        .o_wqe           (o_wqe),
        .o_wqe_cls       (o_wqe_cls),
        .i_wqe_rdy       (i_wqe_rdy),
`ifdef WQE_SCHED_STATS_EN
        .o_ls_grant_cnt  (o_ls_grant_cnt),
        .o_bs_grant_cnt  (o_bs_grant_cnt),
        .o_starve_cnt    (o_starve_cnt),
`endif
        .o_wqe_slot      (o_wqe_slot)
    );

    always #5 clk = ~clk;

    // ---------------- sources and reference model ----------------
    logic [W-1:0] ls_q [$];
    logic [W-1:0] bs_q [NS][$];

    int           n_pass  = 0;
    int           n_total = 0;
    int           cyc     = 0;

    bit           m_free      = 1'b1;  // nothing in flight, a grant may happen
    bit           m_fetch     = 1'b0;  // read data is due this cycle
    bit           m_val       = 1'b0;  // output WQE expected valid
    bit           m_after_rst = 1'b0;  // first cycle after a reset
    logic [W-1:0] m_fl_data, m_out_data;
    bit           m_fl_cls, m_out_cls;
    int           m_fl_slot, m_out_slot;
    int           m_burst = 0;
    int           m_rr    = 0;

    int           g_src [$];   // -1 = LS grant, otherwise BS slot
    int           g_cyc [$];

    function automatic logic [W-1:0] rand_wqe();
        logic [W-1:0] v;
        for (int i = 0; i < W / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // One clock cycle: apply inputs, check outputs against the model, then
    // advance the model across the coming edge. Entered at posedge+1.
    task automatic cycle(input bit rst_in, input bit en_in, input bit rdy_in);
        bit            ls_req, bs_req, force_bs, exp_ren;
        logic [NS-1:0] exp_rd;
        int            exp_slot;
        rst        = rst_in;
        i_sched_en = en_in;
        i_wqe_rdy  = rdy_in;
        i_ls_empty = (ls_q.size() == 0);
        for (int s = 0; s < NS; s++) i_bs_fifo_empty[s] = (bs_q[s].size() == 0);
        i_ls_rdata   = rand_wqe();
        i_bs_wqe     = rand_wqe();
        i_bs_wqe_val = 1'b0;
        if (m_fetch) begin
            if (m_fl_cls) begin
                i_bs_wqe     = m_fl_data;
                i_bs_wqe_val = 1'b1;
            end else begin
                i_ls_rdata = m_fl_data;
            end
        end
        #1;
        exp_ren  = 1'b0;
        exp_rd   = '0;
        exp_slot = 0;
        ls_req   = (ls_q.size() != 0);
        bs_req   = 1'b0;
        for (int s = 0; s < NS; s++) if (bs_q[s].size() != 0) bs_req = 1'b1;
        force_bs = bs_req && (i_ls_burst_max != 0) && (m_burst >= int'(i_ls_burst_max));
        if (m_free && en_in && !rst_in) begin
            if (ls_req && !force_bs) begin
                exp_ren = 1'b1;
            end else if (bs_req) begin
                for (int k = NS - 1; k >= 0; k--)
                    if (bs_q[(m_rr + k) % NS].size() != 0) exp_slot = (m_rr + k) % NS;
                exp_rd[exp_slot] = 1'b1;
            end
        end
        check("ls_ren", W'(o_ls_ren), W'(exp_ren));
        check("bs_rd", W'(o_bs_fifo_rd), W'(exp_rd));
        check("wqe_val", W'(o_wqe_val), W'(m_val));
        if (m_val) begin
            check("wqe", o_wqe, m_out_data);
            check("wqe_cls", W'(o_wqe_cls), W'(m_out_cls));
            check("wqe_slot", W'(o_wqe_slot), W'(m_out_slot));
        end
        if (m_after_rst) begin
            check("rst_wqe", o_wqe, '0);
            check("rst_cls", W'(o_wqe_cls), '0);
            check("rst_slot", W'(o_wqe_slot), '0);
            m_after_rst = 1'b0;
        end
        if (rst_in) begin
            m_free = 1'b1; m_fetch = 1'b0; m_val = 1'b0;
            m_burst = 0; m_rr = 0; m_after_rst = 1'b1;
        end else begin
            if (m_val && rdy_in) begin
                m_val  = 1'b0;
                m_free = 1'b1;
            end
            if (m_fetch) begin
                m_val      = 1'b1;
                m_out_data = m_fl_data;
                m_out_cls  = m_fl_cls;
                m_out_slot = m_fl_slot;
                m_fetch    = 1'b0;
            end
            if (exp_ren) begin
                m_fl_data = ls_q.pop_front();
                m_fl_cls  = 1'b0;
                m_fl_slot = 0;
                m_fetch   = 1'b1;
                m_free    = 1'b0;
                if (!bs_req) m_burst = 0;
                else if (m_burst < (1 << BW) - 1) m_burst++;
                g_src.push_back(-1);
                g_cyc.push_back(cyc);
            end else if (exp_rd != '0) begin
                m_fl_data = bs_q[exp_slot].pop_front();
                m_fl_cls  = 1'b1;
                m_fl_slot = exp_slot;
                m_fetch   = 1'b1;
                m_free    = 1'b0;
                m_burst   = 0;
                m_rr      = (exp_slot + 1) % NS;
                g_src.push_back(exp_slot);
                g_cyc.push_back(cyc);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic keep_full();
        if (ls_q.size() < 2) ls_q.push_back(rand_wqe());
        if (bs_q[1].size() < 2) bs_q[1].push_back(rand_wqe());
    endtask

    initial begin
        int pat_bs [6];
        rst = 1'b1; i_sched_en = 1'b0; i_wqe_rdy = 1'b0; i_ls_burst_max = '0;
        i_ls_empty = 1'b1; i_bs_fifo_empty = '1; i_bs_wqe_val = 1'b0;
        i_ls_rdata = '0; i_bs_wqe = '0;
        repeat (3) @(posedge clk);
        #1;

        // Reset state, sources empty, scheduler disabled
        m_after_rst = 1'b1;
        cycle(1'b0, 1'b0, 1'b1);

        // LS only: three entries, downstream always ready
        for (int i = 0; i < 3; i++) ls_q.push_back(rand_wqe());
        g_src.delete(); g_cyc.delete();
        repeat (12) cycle(1'b0, 1'b1, 1'b1);
        check("ls_only_grants", W'(g_src.size()), W'(3));
        if (g_src.size() == 3) begin
            check("ls_only_gap1", W'(g_cyc[1] - g_cyc[0]), W'(3));
            check("ls_only_gap2", W'(g_cyc[2] - g_cyc[1]), W'(3));
        end

        // BS slots 0, 2, 3 non-empty, LS empty: order 0, 2, 3, 0
        bs_q[0].push_back(rand_wqe()); bs_q[0].push_back(rand_wqe());
        bs_q[2].push_back(rand_wqe()); bs_q[3].push_back(rand_wqe());
        g_src.delete(); g_cyc.delete();
        repeat (14) cycle(1'b0, 1'b1, 1'b1);
        check("bs_rr_grants", W'(g_src.size()), W'(4));
        if (g_src.size() == 4) begin
            check("bs_rr_0", W'(g_src[0]), W'(0));
            check("bs_rr_1", W'(g_src[1]), W'(2));
            check("bs_rr_2", W'(g_src[2]), W'(3));
            check("bs_rr_3", W'(g_src[3]), W'(0));
        end

        // Both classes always pending, burst limit 2: LS, LS, BS repeating
        i_ls_burst_max = 4'd2;
        pat_bs = '{0, 0, 1, 0, 0, 1};
        g_src.delete(); g_cyc.delete();
        for (int k = 0; k < 60 && g_src.size() < 6; k++) begin
            keep_full();
            cycle(1'b0, 1'b1, 1'b1);
        end
        check("burst2_grants", W'(g_src.size() >= 6), W'(1));
        for (int i = 0; i < 6 && i < g_src.size(); i++)
            check("burst2_pattern", W'(g_src[i] >= 0), W'(pat_bs[i]));

        // Same traffic, strict LS priority: no BS grant at all
        i_ls_burst_max = 4'd0;
        g_src.delete(); g_cyc.delete();
        for (int k = 0; k < 60 && g_src.size() < 6; k++) begin
            keep_full();
            cycle(1'b0, 1'b1, 1'b1);
        end
        check("strict_grants", W'(g_src.size() >= 6), W'(1));
        for (int i = 0; i < g_src.size(); i++)
            check("strict_ls_only", W'(g_src[i]), W'(-1));

        // Drain whatever is left, then backpressure for a long OUT phase
        repeat (30) cycle(1'b0, 1'b1, 1'b1);
        ls_q.push_back(rand_wqe()); ls_q.push_back(rand_wqe());
        repeat (13) cycle(1'b0, 1'b1, 1'b0);
        repeat (8) cycle(1'b0, 1'b1, 1'b1);

        // Reset while a WQE is in FETCH; the consumed entry is lost
        for (int k = 0; k < 10 && !m_free; k++) cycle(1'b0, 1'b1, 1'b1);
        bs_q[2].push_back(rand_wqe());
        cycle(1'b0, 1'b1, 1'b1);          // grant
        cycle(1'b1, 1'b1, 1'b1);          // reset during FETCH
        cycle(1'b0, 1'b0, 1'b1);          // outputs cleared, no reads

        // Disabled with sources pending: no read pulses until re-enabled
        ls_q.push_back(rand_wqe()); bs_q[3].push_back(rand_wqe());
        repeat (8) cycle(1'b0, 1'b0, 1'b1);
        repeat (10) cycle(1'b0, 1'b1, 1'b1);

        // Randomised traffic, enables, backpressure, limits and resets
        for (int k = 0; k < 800; k++) begin
            if ($urandom_range(0, 3) == 0 && ls_q.size() < 4) ls_q.push_back(rand_wqe());
            for (int s = 0; s < NS; s++)
                if ($urandom_range(0, 5) == 0 && bs_q[s].size() < 4) bs_q[s].push_back(rand_wqe());
            if ($urandom_range(0, 49) == 0) i_ls_burst_max = BW'($urandom_range(0, 3));
            cycle($urandom_range(0, 199) == 0, $urandom_range(0, 9) != 0, $urandom_range(0, 2) != 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_wqe_grp_scheduler
`default_nettype wire
